sm4_key_expand: RTL and testbench

Iterative SM4 key-schedule unit that sits directly upstream of the SM4 round datapath (`sm4_top` core). It captures a 128-bit user key on `start`, derives the 32 round keys rk[0..31] at one per clock, and stores them in a register file. The round datapath then reads them by round index, in forward order for encryption or reverse order for decryption.

---
 rtl/sm4_pkg.sv | 52 +++++
 rtl/sm4_sbox.sv | 36 +++
 rtl/sm4_key_expand.sv | 110 +++++++++++
 tb/tb_sm4_key_expand.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : sm4_pkg                                                       |
// | Description : Shared SM4 constants and helpers: FK system parameters, CK    |
// |               round constants, 32-bit rotate, the key-schedule linear       |
// |               transform L' and the data-path transform L, and the           |
// |               key-expansion state encoding.                                 |
// | Ports       : none (package)                                                |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
package sm4_pkg;

   localparam int C_ROUNDS = 32;

   // System parameters XORed into the user key before expansion.
   localparam logic [31:0] C_FK [0:3] = '{
      32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
   };

   // Round constants: byte j of CK[i] is (4i+j)*7 mod 256, MSB first.
   localparam logic [31:0] C_CK [0:31] = '{
      32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
      32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
      32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
      32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
      32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
      32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
      32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
      32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
   };

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23).
   function automatic logic [31:0] l_key(input logic [31:0] b);
      return b ^ rotl32(b, 13) ^ rotl32(b, 23);
   endfunction

   // Round-datapath linear transform, kept here so both blocks share one source.
   function automatic logic [31:0] l_data(input logic [31:0] b);
      return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_sbox.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : sm4_sbox                                                      |
// | Description : 8-bit combinational SM4 S-box lookup.                         |
// | Ports       : i_byte [7:0]  input byte                                      |
// |               o_byte [7:0]  substituted byte                                |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module sm4_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [7:0] C_SBOX [0:255] = '{
      8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
      8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
      8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
      8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
      8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
      8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
      8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
      8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
      8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
      8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
      8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
      8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
      8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
      8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
      8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
   };

   assign o_byte = C_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/sm4_key_expand.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : sm4_key_expand                                                |
// | Description : Iterative SM4 key schedule. Captures a 128-bit key on start,  |
// |               derives rk[0..31] at one per clock into a flop register file  |
// |               and serves them combinationally in encrypt or decrypt order.  |
// | Ports       : clk, rst_n        clock / async active-low reset              |
// |               start, key[127:0] expansion request and user key (MK0 = MSW)  |
// |               busy, done        expansion running / 1-cycle completion      |
// |               key_valid         register file holds a full schedule         |
// |               rd_mode, rd_idx   1 = rk[idx], 0 = rk[31-idx]                 |
// |               rk[31:0]          selected round key                          |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module sm4_key_expand (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic         key_valid,
   input  logic         rd_mode,
   input  logic [4:0]   rd_idx,
   output logic [31:0]  rk
);

   import sm4_pkg::*;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_k0, r_k1, r_k2, r_k3;
   logic [31:0] r_rk [0:C_ROUNDS-1];
   logic        r_done;
   logic        r_key_valid;

   logic [31:0] w_t;
   logic [31:0] w_tau;
   logic [31:0] w_new;
   logic [4:0]  w_rd_addr;

   // One round of the schedule: new = K0 ^ L'(tau(K1^K2^K3^CK[cnt])).
   assign w_t = r_k1 ^ r_k2 ^ r_k3 ^ C_CK[r_cnt];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
         sm4_sbox u_sbox (
            .i_byte (w_t[8*gi +: 8]),
            .o_byte (w_tau[8*gi +: 8])
         );
      end
   endgenerate

   assign w_new = r_k0 ^ l_key(w_tau);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 5'd0;
         r_k0        <= 32'd0;
         r_k1        <= 32'd0;
         r_k2        <= 32'd0;
         r_k3        <= 32'd0;
         r_done      <= 1'b0;
         r_key_valid <= 1'b0;
         for (int i = 0; i < C_ROUNDS; i++) begin
            r_rk[i] <= 32'd0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_k0        <= key[127:96] ^ C_FK[0];
                  r_k1        <= key[95:64]  ^ C_FK[1];
                  r_k2        <= key[63:32]  ^ C_FK[2];
                  r_k3        <= key[31:0]   ^ C_FK[3];
                  r_cnt       <= 5'd0;
                  r_key_valid <= 1'b0;
                  r_state     <= RUN;
               end
            end
            RUN: begin
               r_rk[r_cnt] <= w_new;
               r_k0        <= r_k1;
               r_k1        <= r_k2;
               r_k2        <= r_k3;
               r_k3        <= w_new;
               r_cnt       <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_done      <= 1'b1;
                  r_key_valid <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // For a 5-bit index, 31 - idx is simply the bitwise complement.
   assign w_rd_addr = rd_mode ? rd_idx : ~rd_idx;
   assign rk        = r_rk[w_rd_addr];

   assign busy      = (r_state == RUN);
   assign done      = r_done;
   assign key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_sm4_key_expand.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_sm4_key_expand                                             |
// | Description : Scoreboard bench for sm4_key_expand. Stimulus pushes the      |
// |               expected 32-word schedule per completing key; a monitor pops  |
// |               it on done and sweeps rk in both read orders.                 |
// | Ports       : none                                                          |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_sm4_key_expand;

   localparam int HALF = 100;
   localparam logic [127:0] C_KAT = 128'h0123456789ABCDEFFEDCBA9876543210;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic         busy, done, key_valid;
   logic         rd_mode;
   logic [4:0]   rd_idx;
   logic [31:0]  rk;

   int n_cmp = 0;
   int n_bad = 0;
   int zero_req = 0;

   logic [1023:0] sb [$];

   sm4_key_expand dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
      .busy      (busy),
      .done      (done),
      .key_valid (key_valid),
      .rd_mode   (rd_mode),
      .rd_idx    (rd_idx),
      .rk        (rk)
   );

   always #HALF clk = ~clk;

   // ---------------- reference model ----------------
   bit [7:0] SB [256] = '{
      8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
      8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
      8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
      8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
      8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
      8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
      8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
      8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
      8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
      8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
      8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
      8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
      8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
      8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
      8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
   };

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] ck_word(input int i);
      logic [31:0] w;
      w = 32'd0;
      for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
      return w;
   endfunction

   // Whole schedule as a 36-word sequence K[0..35]; rk[i] = K[i+4].
   function automatic logic [1023:0] ref_sched(input logic [127:0] mk);
      logic [31:0] kw [36];
      logic [31:0] fk [4];
      logic [31:0] t, b;
      logic [1023:0] r;
      fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
      for (int i = 0; i < 4; i++) kw[i] = mk[127 - 32 * i -: 32] ^ fk[i];
      r = '0;
      for (int i = 0; i < 32; i++) begin
         t = kw[i + 1] ^ kw[i + 2] ^ kw[i + 3] ^ ck_word(i);
         b = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
         kw[i + 4] = kw[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
         r[i * 32 +: 32] = kw[i + 4];
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      int zero_seen;
      logic [1023:0] e;
      zero_seen = 0;
      rd_mode = 1'b1;
      rd_idx  = 5'd0;
      forever begin
         @(negedge clk);
         if (zero_req != zero_seen) begin
            zero_seen = zero_req;
            for (int i = 0; i < 32; i++) begin
               rd_mode = 1'b1; rd_idx = 5'(i); #1;
               chk($sformatf("rk_reset[%0d]", i), rk, 32'd0);
            end
         end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_underflow: done seen with no expected schedule");
            end else begin
               e = sb.pop_front();
               for (int i = 0; i < 32; i++) begin
                  rd_mode = 1'b1; rd_idx = 5'(i); #1;
                  chk($sformatf("rk_enc[%0d]", i), rk, e[i * 32 +: 32]);
                  rd_mode = 1'b0; #1;
                  chk($sformatf("rk_dec[%0d]", i), rk, e[(31 - i) * 32 +: 32]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [127:0] k, input bit push, input bit kat);
      logic [1023:0] e;
      if (push) begin
         e = ref_sched(k);
         if (kat) begin
            e[31:0]     = 32'hF12186F9;
            e[63:32]    = 32'h41662B61;
            e[1023:992] = 32'h9124A012;
         end
         sb.push_back(e);
      end
      start = 1'b1;
      key   = k;
      @(posedge clk); #1;
      start = 1'b0;
      key   = {$urandom, $urandom, $urandom, $urandom};
      chk("kv_clear_on_start", 32'(key_valid), 32'd0);
      chk("busy_rise", 32'(busy), 32'd1);
      chk("done_single_pulse", 32'(done), 32'd0);
   endtask

   // Entered one cycle after the accepting edge; returns in the done cycle.
   task automatic wait_done(input int inj, input logic [127:0] k2);
      int lat, bcnt;
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy) bcnt++;
         start = (lat == inj);
         if (lat == inj) key = k2;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk("latency", 32'(lat), 32'd32);
      chk("busy_cycles", 32'(bcnt), 32'd32);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("kv_at_done", 32'(key_valid), 32'd1);
   endtask

   initial begin : stimulus
      bit done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      key   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_kv", 32'(key_valid), 32'd0);
      zero_req++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer schedule, then a couple of idle cycles.
      issue(C_KAT, 1'b1, 1'b1);
      wait_done(-1, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("done_dropped", 32'(done), 32'd0);
      chk("kv_held", 32'(key_valid), 32'd1);

      // Second start mid-run must be ignored.
      issue(C_KAT, 1'b1, 1'b1);
      wait_done(10, {$urandom, $urandom, $urandom, $urandom});
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a run.
      issue({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_kv", 32'(key_valid), 32'd0);
      zero_req++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) done_seen = 1'b1;
      end
      chk("midrst_no_done", 32'(done_seen), 32'd0);
      chk("midrst_kv_after", 32'(key_valid), 32'd0);
      chk("midrst_busy_after", 32'(busy), 32'd0);

      // KAT, then key 0 started in its done cycle, then 100 random keys chained.
      issue(C_KAT, 1'b1, 1'b1);
      wait_done(-1, '0);
      issue(128'd0, 1'b1, 1'b0);
      wait_done(-1, '0);
      for (int n = 0; n < 100; n++) begin
         issue({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
         wait_done(-1, '0);
      end
      @(posedge clk); #1;
      chk("final_done_low", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
